// File: rtl/dfp_burst_adapter.sv
// Memory-side responder for the cache dfp port: turns one cacheline read or write
// into a BEATS-long burst on the bmem interface and answers with a single dfp_resp.
module dfp_burst_adapter #(
  parameter int BEATS  = 4,
  parameter int BEAT_W = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [31:0]               dfp_addr,
  input  logic                      dfp_read,
  input  logic                      dfp_write,
  input  logic [BEATS*BEAT_W-1:0]   dfp_wdata,
  output logic [BEATS*BEAT_W-1:0]   dfp_rdata,
  output logic                      dfp_resp,
  output logic [31:0]               bmem_addr,
  output logic                      bmem_read,
  output logic                      bmem_write,
  output logic [BEAT_W-1:0]         bmem_wdata,
  input  logic                      bmem_ready,
  input  logic [BEAT_W-1:0]         bmem_rdata,
  input  logic                      bmem_rvalid
);

  localparam int LINE_W = BEATS * BEAT_W;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_REQ,
    RD_WAIT,
    RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   rline_q, rline_d;

  // Byte-offset bits of the line address are intentionally dropped.
  logic addr_lo_unused;
  assign addr_lo_unused = ^dfp_addr[OFF_W-1:0];

  // State register and datapath flops.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      // NOTE: the line buffers are plain flops, not a RAM, so resetting them is
      // cheap and gives dfp_rdata a defined zero out of reset.
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  // Next-state logic. Write has priority over read when both are pending.
  always_comb begin
    // NOTE: a default for every comb output up front keeps this block latch-free.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (dfp_write)     state_d = WRITE;
        else if (dfp_read) state_d = RD_REQ;
      end
      WRITE:   if (bmem_ready && cnt_q == LAST_BEAT)  state_d = RESP;
      RD_REQ:  if (bmem_ready)                        state_d = RD_WAIT;
      RD_WAIT: if (bmem_rvalid && cnt_q == LAST_BEAT) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: latch the request on accept, step the beat counter, gather read beats.
  always_comb begin
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      IDLE: begin
        if (dfp_write || dfp_read) begin
          addr_d = {dfp_addr[31:OFF_W], {OFF_W{1'b0}}};
          cnt_d  = '0;
        end
        if (dfp_write) wline_d = dfp_wdata;
      end
      WRITE: begin
        if (bmem_ready) cnt_d = cnt_q + CNT_W'(1);
      end
      RD_WAIT: begin
        if (bmem_rvalid) begin
          rline_d[int'(cnt_q)*BEAT_W +: BEAT_W] = bmem_rdata;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs decoded from the registered state only.
  always_comb begin
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_addr  = '0;
    bmem_wdata = '0;
    dfp_resp   = 1'b0;
    unique case (state_q)
      WRITE: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_q;
        bmem_wdata = wline_q[int'(cnt_q)*BEAT_W +: BEAT_W];
      end
      RD_REQ: begin
        bmem_read = 1'b1;
        bmem_addr = addr_q;
      end
      RESP:    dfp_resp = 1'b1;
      default: ;
    endcase
  end

  assign dfp_rdata = rline_q;

endmodule

// File: tb/tb_dfp_burst_adapter.sv
// Directed self-checking bench for dfp_burst_adapter. Outputs are sampled and
// inputs driven at the falling clock edge, one bench step per clock cycle.
module tb_dfp_burst_adapter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int errors = 0;
  int checks = 0;
  logic [255:0] last_rd;

  dfp_burst_adapter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Read burst from the RD_REQ cycle on. req_wait = cycles ready stays low in
  // RD_REQ, gap = idle cycles before each beat, hold keeps dfp_read high after resp.
  task automatic read_from_req(input logic [31:0] addr, input logic [255:0] line,
                               input int req_wait, input int gap, input bit hold,
                               input string tag);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:5], 5'b0};
    for (int i = 0; i <= req_wait; i++) begin
      @(negedge clk);
      checks++;
      if (bmem_read !== 1'b1) begin errors++; $display("FAIL %s bmem_read: got %b exp 1", tag, bmem_read); end
      checks++;
      if (bmem_addr !== exp_addr) begin errors++; $display("FAIL %s bmem_addr: got %h exp %h", tag, bmem_addr, exp_addr); end
      bmem_ready = (i == req_wait);
    end
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        checks++;
        if ({dfp_resp, bmem_read} !== 2'b00) begin errors++; $display("FAIL %s gap resp/read: got %b exp 00", tag, {dfp_resp, bmem_read}); end
        bmem_rvalid = 1'b0;
      end
      @(negedge clk);
      checks++;
      if ({dfp_resp, bmem_read} !== 2'b00) begin errors++; $display("FAIL %s beat%0d resp/read: got %b exp 00", tag, k, {dfp_resp, bmem_read}); end
      bmem_rvalid = 1'b1;
      bmem_rdata  = line[64*k +: 64];
    end
    @(negedge clk);
    checks++;
    if (dfp_resp !== 1'b1) begin errors++; $display("FAIL %s resp: got %b exp 1", tag, dfp_resp); end
    checks++;
    if (dfp_rdata !== line) begin errors++; $display("FAIL %s rdata: got %h exp %h", tag, dfp_rdata, line); end
    bmem_rvalid = 1'b0;
    if (!hold) dfp_read = 1'b0;
    last_rd = line;
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                          input int req_wait, input int gap, input bit hold, input string tag);
    dfp_addr    = addr;
    dfp_read    = 1'b1;
    bmem_ready  = 1'b1;
    bmem_rvalid = 1'b0;
    read_from_req(addr, line, req_wait, gap, hold, tag);
  endtask

  // Write burst from the IDLE accept cycle through the RESP cycle.
  task automatic write_burst(input logic [31:0] addr, input logic [255:0] line,
                             input bit toggle, input string tag);
    int k;
    int cyc;
    logic rdy;
    logic [31:0] exp_addr;
    exp_addr   = {addr[31:5], 5'b0};
    dfp_addr   = addr;
    dfp_write  = 1'b1;
    dfp_wdata  = line;
    bmem_ready = 1'b1;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 32) begin
      @(negedge clk);
      checks++;
      if ({bmem_write, bmem_read, dfp_resp} !== 3'b100) begin errors++; $display("FAIL %s beat%0d ctl: got %b exp 100", tag, k, {bmem_write, bmem_read, dfp_resp}); end
      checks++;
      if (bmem_wdata !== line[64*k +: 64]) begin errors++; $display("FAIL %s beat%0d wdata: got %h exp %h", tag, k, bmem_wdata, line[64*k +: 64]); end
      checks++;
      if (bmem_addr !== exp_addr) begin errors++; $display("FAIL %s beat%0d addr: got %h exp %h", tag, k, bmem_addr, exp_addr); end
      rdy = toggle ? (cyc % 2 == 0) : 1'b1;
      bmem_ready = rdy;
      if (rdy) k++;
      cyc++;
    end
    checks++;
    if (cyc !== (toggle ? 7 : 4)) begin errors++; $display("FAIL %s write cycles: got %0d exp %0d", tag, cyc, toggle ? 7 : 4); end
    @(negedge clk);
    checks++;
    if ({dfp_resp, bmem_write} !== 2'b10) begin errors++; $display("FAIL %s resp/write: got %b exp 10", tag, {dfp_resp, bmem_write}); end
    checks++;
    if (dfp_rdata !== last_rd) begin errors++; $display("FAIL %s rdata disturbed: got %h exp %h", tag, dfp_rdata, last_rd); end
    dfp_write  = 1'b0;
    bmem_ready = 1'b1;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    checks++;
    if ({dfp_resp, bmem_read, bmem_write} !== 3'b000) begin errors++; $display("FAIL %s idle ctl: got %b exp 000", tag, {dfp_resp, bmem_read, bmem_write}); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; dfp_addr = '0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
    bmem_ready = 1'b0; bmem_rdata = '0; bmem_rvalid = 1'b0; last_rd = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata, dfp_rdata} !== '0) begin
      errors++; $display("FAIL reset outputs: got resp=%b rd=%b wr=%b addr=%h rdata=%h exp all 0", dfp_resp, bmem_read, bmem_write, bmem_addr, dfp_rdata);
    end
    rst_n = 1'b1;
    expect_idle("reset_release");
  endtask

  task automatic test_read();
    run_read(32'h0000_1234, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                             64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0, 0, 0, "read");
    expect_idle("read_after");
    run_read(32'hABCD_EF1F, {64'h0D0D_0D0D_0000_0004, 64'h0C0C_0C0C_0000_0003,
                             64'h0B0B_0B0B_0000_0002, 64'h0A0A_0A0A_0000_0001}, 1, 2, 0, "read_gaps");
    expect_idle("read_gaps_after");
  endtask

  task automatic test_write();
    write_burst(32'h8000_0047, {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 1, "write_toggle");
    expect_idle("write_toggle_after");
    write_burst(32'h0000_0020, {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 0, "write_fast");
    expect_idle("write_fast_after");
  endtask

  task automatic test_rvalid_ignored();
    bmem_rvalid = 1'b1;
    bmem_rdata  = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (dfp_resp !== 1'b0) begin errors++; $display("FAIL rvalid_idle resp: got %b exp 0", dfp_resp); end
      checks++;
      if (dfp_rdata !== last_rd) begin errors++; $display("FAIL rvalid_idle rdata: got %h exp %h", dfp_rdata, last_rd); end
    end
    write_burst(32'h0000_4000, {4{64'h7777_0000_7777_0000}}, 0, "rvalid_write");
    bmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if ({dfp_resp, dfp_rdata} !== {1'b0, last_rd}) begin errors++; $display("FAIL rvalid_after resp/rdata: got %b/%h exp 0/%h", dfp_resp, dfp_rdata, last_rd); end
  endtask

  task automatic test_both_pending();
    dfp_read = 1'b1;
    write_burst(32'h0000_9000, {64'h1, 64'h2, 64'h3, 64'h4}, 0, "both_write");
    expect_idle("both_gap");
    read_from_req(32'h0000_9000, {64'h9999_0004, 64'h9999_0003, 64'h9999_0002, 64'h9999_0001},
                  0, 0, 0, "both_read");
    expect_idle("both_after");
  endtask

  task automatic test_reset_mid_read();
    dfp_addr = 32'h0000_5500; dfp_read = 1'b1; bmem_ready = 1'b1; bmem_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (bmem_read !== 1'b1) begin errors++; $display("FAIL rstmid req: got %b exp 1", bmem_read); end
    @(negedge clk); bmem_rvalid = 1'b1; bmem_rdata = 64'hAAAA_0000_0000_0000;
    @(negedge clk); bmem_rdata = 64'hBBBB_0000_0000_0000;
    @(negedge clk); bmem_rvalid = 1'b0;
    rst_n = 1'b0;
    last_rd = '0;
    #1;
    checks++;
    if ({dfp_resp, bmem_read, bmem_write, bmem_addr, bmem_wdata, dfp_rdata} !== '0) begin
      errors++; $display("FAIL rstmid outputs: got resp=%b rd=%b wr=%b addr=%h rdata=%h exp all 0", dfp_resp, bmem_read, bmem_write, bmem_addr, dfp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dfp_read = 1'b0;
    for (int i = 0; i < 3; i++) expect_idle("rstmid_quiet");
    run_read(32'h0000_5500, {64'h4004, 64'h3003, 64'h2002, 64'h1001}, 0, 0, 0, "rstmid_fresh");
    expect_idle("rstmid_after");
  endtask

  task automatic test_back_to_back();
    run_read(32'h0000_7000, {64'hA4, 64'hA3, 64'hA2, 64'hA1}, 0, 0, 1, "b2b_first");
    expect_idle("b2b_gap");
    read_from_req(32'h0000_7000, {64'hB4, 64'hB3, 64'hB2, 64'hB1}, 0, 0, 0, "b2b_second");
    expect_idle("b2b_after");
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_rvalid_ignored();
    test_both_pending();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
